// File: rtl/reg_file.sv
// Two-read, one-write register file with x0 hardwired to zero and write-to-read bypass.
// Contents clear asynchronously on rst_n; reads are combinational and forced to zero during reset.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              write_en;

    // Writes to x0 are dropped here, so regs[0] never leaves its reset value.
    assign write_en = reg_write && (rd_addr != '0);

    // NOTE: every entry is reset so no X state survives reset; this costs a flop-based array (no RAM macro).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;  // NOTE: non-blocking for all sequential state to avoid simulation races.
            end
        end else if (write_en) begin
            regs[rd_addr] <= rd_data;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic              rst_active_n,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] value;
        value = stored;  // NOTE: default first so the combinational path never infers a latch.
        if (!rst_active_n || addr == '0) begin
            value = '0;
        end else if (wr_en && addr == wr_addr) begin
            value = wr_data;
        end
        return value;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr, rst_n, write_en, rd_addr, rd_data, regs[rs1_addr]);
        rs2_data = read_port(rs2_addr, rst_n, write_en, rd_addr, rd_data, regs[rs2_addr]);
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: stimulus pushes expected read values, a monitor pops and compares.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .reg_write(reg_write),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: whenever the stimulus marks the outputs as presented, pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (q.size() == 0) begin
                check("unexpected_sample", 32'h1, 32'h0);
            end else begin
                e = q.pop_front();
                check({e.name, ".rs1"}, rs1_data, e.e1);
                check({e.name, ".rs2"}, rs2_data, e.e2);
            end
        end
    end

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2);
        reg_write = we;
        rd_addr   = wa;
        rd_data   = wd;
        rs1_addr  = a1;
        rs2_addr  = a2;
    endtask

    task automatic expect_out(input string name, input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        #1;
        e.name = name;
        e.e1   = e1;
        e.e2   = e2;
        q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 5'd1, 32'hFFFF_FFFF, 5'd1, 5'd31);
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_out("reset_read", 32'h0, 32'h0);

        rst_n = 1'b1;
        drive(1'b1, 5'd1, 32'hAAAA_BBBB, 5'd1, 5'd31);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 5'd2, 32'h1234_5678, 5'd1, 5'd2);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 5'd2, 32'h0, 5'd1, 5'd2);
        expect_out("write_readback", 32'hAAAA_BBBB, 32'h1234_5678);

        drive(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
        expect_out("x0_write_pre_edge", 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        expect_out("x0_write_post_edge", 32'h0, 32'h0);
        drive(1'b0, 5'd0, 32'hDEAD_BEEF, 5'd1, 5'd2);
        expect_out("x0_no_side_effect", 32'hAAAA_BBBB, 32'h1234_5678);

        drive(1'b1, 5'd5, 32'hCAFE_F00D, 5'd5, 5'd1);
        expect_out("bypass_same_cycle", 32'hCAFE_F00D, 32'hAAAA_BBBB);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 5'd5, 32'h0, 5'd5, 5'd5);
        expect_out("bypass_committed", 32'hCAFE_F00D, 32'hCAFE_F00D);

        drive(1'b0, 5'd3, 32'hFFFF_FFFF, 5'd3, 5'd3);
        expect_out("gated_no_bypass", 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        expect_out("gated_no_write", 32'h0, 32'h0);

        drive(1'b1, 5'd4, 32'h1111_1111, 5'd4, 5'd31);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 5'd4, 32'h2222_2222, 5'd4, 5'd31);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 5'd31, 32'h5A5A_5A5A, 5'd4, 5'd1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd31);
        expect_out("back_to_back_and_x31", 32'h2222_2222, 32'h5A5A_5A5A);

        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
        expect_out("pre_async_reset", 32'hAAAA_BBBB, 32'h5A5A_5A5A);
        rst_n = 1'b0;
        expect_out("async_reset_no_edge", 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd5);
        expect_out("contents_discarded", 32'h0, 32'h0);
        drive(1'b1, 5'd1, 32'h0F0F_0F0F, 5'd2, 5'd31);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        expect_out("first_write_after_reset", 32'h0F0F_0F0F, 32'h0);

        for (int i = 0; i < 100 && q.size() != 0; i++) #1;
        if (q.size() != 0) check("scoreboard_drain", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 5, meaning register address width; register count is 2**ADDR_W (32).
REQ-003 The block SHALL have a port list consisting of exactly the ports in REQ-004 to REQ-012.
REQ-004 clk  input  1  sole clock; all writes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 reg_write  input  1  write enable for the write port.
REQ-007 rd_addr  input  ADDR_W  write destination register index.
REQ-008 rd_data  input  DATA_W  write data.
REQ-009 rs1_addr  input  ADDR_W  read port 1 register index.
REQ-010 rs2_addr  input  ADDR_W  read port 2 register index.
REQ-011 rs1_data  output  DATA_W  read port 1 data.
REQ-012 rs2_data  output  DATA_W  read port 2 data.

Function
REQ-013 The block SHALL hold 2**ADDR_W registers x0..x31 of DATA_W bits each.
REQ-014 Register x0 SHALL read as 0 at all times; writes to x0 SHALL be discarded with no side effect.
REQ-015 On a rising clk edge with rst_n=1, reg_write=1 and rd_addr!=0, register[rd_addr] SHALL take rd_data; all other registers SHALL be unchanged.
REQ-016 With reg_write=0, no register SHALL change on any clock edge.
REQ-017 Both read ports SHALL be combinational, zero-cycle latency: rsN_data = register[rsN_addr], updating within the same cycle as an address change.
REQ-018 The two read ports SHALL be fully independent; both SHALL return the same value when given the same address.
REQ-019 Write-to-read bypass: when reg_write=1, rd_addr!=0 and rsN_addr==rd_addr, rsN_data SHALL equal rd_data combinationally (before the edge).
REQ-020 Bypass SHALL never apply for rd_addr=0; reading x0 SHALL return 0 even while writing to x0.
REQ-021 A written value SHALL be visible on any read port addressing that register from the cycle after the write edge onward, until overwritten or reset.
REQ-022 Back-to-back writes to the same register on consecutive edges SHALL leave the last written value.
REQ-023 The block SHALL contain no X-propagating state after reset; every output SHALL be a defined value whenever inputs are defined.

Reset
REQ-024 rst_n=0 SHALL immediately clear all registers to 0, independent of clk.
REQ-025 While rst_n=0, writes SHALL be ignored and both read ports SHALL return 0 (bypass disabled).
REQ-026 Reset asserted mid-operation SHALL discard all prior contents; first write is accepted on the first rising clk edge after rst_n deasserts.

Verification
REQ-027 Reset then read: hold rst_n=0, read x1 and x31 -> rs1_data=0, rs2_data=0.
REQ-028 Write/readback: write x1=AAAABBBB, then x2=12345678 on consecutive edges, reg_write=0, read rs1=x1, rs2=x2 -> AAAABBBB, 12345678.
REQ-029 x0 protection: write x0=DEADBEEF with reg_write=1, read rs1=x0, rs2=x0 -> both 00000000, x1 and x2 unchanged.
REQ-030 Bypass: reg_write=1, rd_addr=5, rd_data=CAFEF00D, rs1_addr=5 before edge -> rs1_data=CAFEF00D same cycle; after edge with reg_write=0 -> still CAFEF00D.
REQ-031 Write-enable gating: reg_write=0, rd_addr=3, rd_data=FFFFFFFF over several edges -> x3 reads 0.
REQ-032 Async reset mid-run: after x1=AAAABBBB, drop rst_n between clock edges -> rs1_data (x1) becomes 0 immediately without a clk edge.
